// File: rtl/estacao_reserva_ua_pkg.sv
// Shared definitions for the add/sub/address reservation station.
// Contents: widths, opcodes, the per-entry record, the FU-side state enum
// and a helper that maps an entry index to its broadcast tag.
package estacao_reserva_ua_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 16;
    localparam int CDB_W  = TAG_W + DATA_W;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_LD   = 3'b011,
        OP_ST   = 3'b100
    } op_e;

    // One station slot. busy/disp encode FREE/WAIT/READY/EXEC together
    // with the Q fields.
    typedef struct packed {
        logic              busy;
        logic              disp;
        op_e               op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
    } rs_entry_t;

    // Functional unit side: either nothing dispatched or one entry executing.
    typedef enum logic {
        FU_IDLE = 1'b0,
        FU_EXEC = 1'b1
    } fu_state_e;

    function automatic logic [TAG_W-1:0] entry_tag(input int base_id, input int idx);
        return TAG_W'(base_id + idx);
    endfunction

endpackage

// File: rtl/estacao_reserva_ua_if.sv
// Bundle of the station's issue, CDB and functional-unit signals.
// slave  : the reservation station itself.
// master : the surroundings (issue stage, CDB, functional unit).
interface estacao_reserva_ua_if #(
    parameter int N_ENTRIES = 3
);
    import estacao_reserva_ua_pkg::*;

    // issue stage
    logic                 issue_valid;
    logic [2:0]           issue_op;
    logic [DATA_W-1:0]    issue_vj;
    logic [DATA_W-1:0]    issue_vk;
    logic [TAG_W-1:0]     issue_qj;
    logic [TAG_W-1:0]     issue_qk;
    logic                 issue_ready;
    logic [TAG_W-1:0]     issue_tag;
    // common data bus
    logic                 cdb_valid;
    logic [CDB_W-1:0]     cdb_bus;
    // functional unit
    logic                 fu_conf;
    logic [TAG_W-1:0]     fu_tag;
    logic [DATA_W-1:0]    Dado1;
    logic [DATA_W-1:0]    Dado2;
    logic [2:0]           op;
    logic [TAG_W-1:0]     ID_out;
    // debug
    logic [N_ENTRIES-1:0] busy_vec;

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
        input  cdb_valid, cdb_bus, fu_conf, fu_tag,
        output issue_ready, issue_tag, Dado1, Dado2, op, ID_out, busy_vec
    );

    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
        output cdb_valid, cdb_bus, fu_conf, fu_tag,
        input  issue_ready, issue_tag, Dado1, Dado2, op, ID_out, busy_vec
    );

endinterface

// File: rtl/estacao_reserva_ua_prio_enc_low.sv
// Lowest-set-bit priority encoder.
// Ports: req   - request vector
//        valid - at least one request bit set
//        idx   - index of the lowest set bit (0 when valid=0)
module prio_enc_low #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a missing path would otherwise infer a latch.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/estacao_reserva_ua.sv
// Reservation station feeding the integer add/sub/address unit.
// Holds issued instructions until both operands are valid (capturing them
// from the CDB), then dispatches one at a time and holds the FU inputs
// stable until the unit confirms completion with the matching tag.
// Ports: CLK - clock, rising edge
//        CLR - asynchronous reset, active low
//        bus - station side of estacao_reserva_ua_if (issue, CDB, FU, debug)
module estacao_reserva_ua
    import estacao_reserva_ua_pkg::*;
#(
    parameter int N_ENTRIES = 3,
    parameter int BASE_ID   = 1
) (
    input logic                  CLK,
    input logic                  CLR,
    estacao_reserva_ua_if.slave  bus
);

    localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    rs_entry_t            ent_q [N_ENTRIES];
    rs_entry_t            ent_d [N_ENTRIES];

    logic [N_ENTRIES-1:0] free_vec;
    logic [N_ENTRIES-1:0] ready_vec;
    logic [N_ENTRIES-1:0] busy_v;
    logic                 free_any;
    logic                 ready_any;
    logic [IDX_W-1:0]     free_idx;
    logic [IDX_W-1:0]     ready_idx;

    fu_state_e            fu_state_q;
    fu_state_e            fu_state_d;
    logic                 do_dispatch;
    logic                 do_complete;

    logic [DATA_W-1:0]    dado1_q, dado1_d;
    logic [DATA_W-1:0]    dado2_q, dado2_d;
    op_e                  op_q, op_d;
    logic [TAG_W-1:0]     id_q, id_d;

    logic [TAG_W-1:0]     cdb_tag;
    logic [DATA_W-1:0]    cdb_val;
    logic                 cdb_hit;
    logic                 issue_take;

    assign cdb_tag    = bus.cdb_bus[CDB_W-1:DATA_W];
    assign cdb_val    = bus.cdb_bus[DATA_W-1:0];
    assign cdb_hit    = bus.cdb_valid && (cdb_tag != TAG_NONE);
    assign issue_take = bus.issue_valid && free_any;

    // Per-entry status from registered state only, so a capture on one edge
    // makes the entry dispatchable on the following edge at the earliest.
    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        busy_v    = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            free_vec[i]  = !ent_q[i].busy;
            busy_v[i]    = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && !ent_q[i].disp &&
                           (ent_q[i].qj == TAG_NONE) && (ent_q[i].qk == TAG_NONE);
        end
    end

    prio_enc_low #(.N(N_ENTRIES), .IDX_W(IDX_W)) u_free_sel (
        .req   (free_vec),
        .valid (free_any),
        .idx   (free_idx)
    );

    prio_enc_low #(.N(N_ENTRIES), .IDX_W(IDX_W)) u_ready_sel (
        .req   (ready_vec),
        .valid (ready_any),
        .idx   (ready_idx)
    );

    // FU-side FSM: next state and the registered FU operand/tag outputs.
    // Completion drops to idle, so the next dispatch is one edge later.
    always_comb begin
        fu_state_d  = fu_state_q;
        do_dispatch = 1'b0;
        do_complete = 1'b0;
        dado1_d     = dado1_q;
        dado2_d     = dado2_q;
        op_d        = op_q;
        id_d        = id_q;
        case (fu_state_q)
            FU_IDLE: begin
                if (ready_any) begin
                    do_dispatch = 1'b1;
                    fu_state_d  = FU_EXEC;
                    dado1_d     = ent_q[ready_idx].vj;
                    dado2_d     = ent_q[ready_idx].vk;
                    op_d        = ent_q[ready_idx].op;
                    id_d        = entry_tag(BASE_ID, int'(ready_idx));
                end
            end
            FU_EXEC: begin
                // Tag-0 pulses and stale tags simply fail this compare.
                if (bus.fu_conf && (bus.fu_tag == id_q)) begin
                    do_complete = 1'b1;
                    fu_state_d  = FU_IDLE;
                    dado1_d     = '0;
                    dado2_d     = '0;
                    op_d        = OP_NONE;
                    id_d        = TAG_NONE;
                end
            end
            default: fu_state_d = FU_IDLE;
        endcase
    end

    // Entry updates. Issue only targets an entry free in registered state,
    // so it never collides with the entry being completed this edge.
    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            ent_d[i] = ent_q[i];

            if (cdb_hit && ent_q[i].busy) begin
                if (ent_q[i].qj == cdb_tag) begin
                    ent_d[i].vj = cdb_val;
                    ent_d[i].qj = TAG_NONE;
                end
                if (ent_q[i].qk == cdb_tag) begin
                    ent_d[i].vk = cdb_val;
                    ent_d[i].qk = TAG_NONE;
                end
            end

            if (do_dispatch && (ready_idx == IDX_W'(i))) begin
                ent_d[i].disp = 1'b1;
            end

            // At most one entry has disp set: the one currently executing.
            if (do_complete && ent_q[i].disp) begin
                ent_d[i] = '0;
            end

            if (issue_take && (free_idx == IDX_W'(i))) begin
                ent_d[i].busy = 1'b1;
                ent_d[i].disp = 1'b0;
                ent_d[i].op   = op_e'(bus.issue_op);
                // Bypass: a producer broadcasting in the issue cycle would
                // otherwise be missed forever.
                if (cdb_hit && (bus.issue_qj == cdb_tag)) begin
                    ent_d[i].vj = cdb_val;
                    ent_d[i].qj = TAG_NONE;
                end else begin
                    ent_d[i].vj = bus.issue_vj;
                    ent_d[i].qj = bus.issue_qj;
                end
                if (cdb_hit && (bus.issue_qk == cdb_tag)) begin
                    ent_d[i].vk = cdb_val;
                    ent_d[i].qk = TAG_NONE;
                end else begin
                    ent_d[i].vk = bus.issue_vk;
                    ent_d[i].qk = bus.issue_qk;
                end
            end
        end
    end

    // NOTE: the entry array is reset in full, not just its busy bits: a
    // reset must discard in-flight work and leave values observable as zero.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            fu_state_q <= FU_IDLE;
            dado1_q    <= '0;
            dado2_q    <= '0;
            op_q       <= OP_NONE;
            id_q       <= TAG_NONE;
        end else begin
            fu_state_q <= fu_state_d;
            dado1_q    <= dado1_d;
            dado2_q    <= dado2_d;
            op_q       <= op_d;
            id_q       <= id_d;
        end
    end

    assign bus.issue_ready = free_any;
    assign bus.issue_tag   = free_any ? entry_tag(BASE_ID, int'(free_idx)) : TAG_NONE;
    assign bus.Dado1       = dado1_q;
    assign bus.Dado2       = dado2_q;
    assign bus.op          = op_q;
    assign bus.ID_out      = id_q;
    assign bus.busy_vec    = busy_v;

endmodule

// File: tb/tb_estacao_reserva_ua.sv
// Self-checking bench for estacao_reserva_ua: directed scenarios followed by
// random traffic, all compared against a slot-level reference model.
module tb_estacao_reserva_ua;

    localparam int N    = 3;
    localparam int BASE = 1;

    logic CLK;
    logic CLR;

    estacao_reserva_ua_if #(.N_ENTRIES(N)) bus ();

    estacao_reserva_ua #(.N_ENTRIES(N), .BASE_ID(BASE)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    bit          m_busy [N];
    bit          m_disp [N];
    logic [2:0]  m_opc  [N];
    logic [15:0] m_vj   [N];
    logic [15:0] m_vk   [N];
    logic [2:0]  m_qj   [N];
    logic [2:0]  m_qk   [N];
    logic [15:0] m_d1, m_d2;
    logic [2:0]  m_op, m_id;   // m_id = 0 means the unit is idle

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_disp[i] = 0; m_opc[i] = 0;
            m_vj[i] = 0; m_vk[i] = 0; m_qj[i] = 0; m_qk[i] = 0;
        end
        m_d1 = 0; m_d2 = 0; m_op = 0; m_id = 0;
    endfunction

    function automatic int model_first_free();
        for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic bit model_all_free();
        for (int i = 0; i < N; i++) if (m_busy[i]) return 0;
        return 1;
    endfunction

    // One clock edge of the station, applied to the sampled inputs.
    function automatic void model_step();
        int fi, ri, ci;
        logic [2:0]  t;
        logic [15:0] v;
        bit hit;
        fi = model_first_free();
        ri = -1;
        for (int i = 0; i < N; i++)
            if (ri < 0 && m_busy[i] && !m_disp[i] && m_qj[i] == 0 && m_qk[i] == 0) ri = i;
        t   = bus.cdb_bus[18:16];
        v   = bus.cdb_bus[15:0];
        hit = bus.cdb_valid && (t != 0);

        if (m_id != 0) begin
            if (bus.fu_conf && bus.fu_tag == m_id) begin
                ci = int'(m_id) - BASE;
                m_busy[ci] = 0; m_disp[ci] = 0; m_opc[ci] = 0;
                m_vj[ci] = 0; m_vk[ci] = 0; m_qj[ci] = 0; m_qk[ci] = 0;
                m_d1 = 0; m_d2 = 0; m_op = 0; m_id = 0;
            end
        end else if (ri >= 0) begin
            m_d1 = m_vj[ri]; m_d2 = m_vk[ri]; m_op = m_opc[ri];
            m_id = 3'(ri + BASE);
            m_disp[ri] = 1;
        end

        if (hit) begin
            for (int i = 0; i < N; i++) begin
                if (m_busy[i] && m_qj[i] == t) begin m_vj[i] = v; m_qj[i] = 0; end
                if (m_busy[i] && m_qk[i] == t) begin m_vk[i] = v; m_qk[i] = 0; end
            end
        end

        if (bus.issue_valid && fi >= 0) begin
            m_busy[fi] = 1; m_disp[fi] = 0; m_opc[fi] = bus.issue_op;
            if (hit && bus.issue_qj == t) begin m_vj[fi] = v; m_qj[fi] = 0; end
            else begin m_vj[fi] = bus.issue_vj; m_qj[fi] = bus.issue_qj; end
            if (hit && bus.issue_qk == t) begin m_vk[fi] = v; m_qk[fi] = 0; end
            else begin m_vk[fi] = bus.issue_vk; m_qk[fi] = bus.issue_qk; end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus.issue_valid = 0; bus.issue_op = 0;
        bus.issue_vj = 0; bus.issue_vk = 0; bus.issue_qj = 0; bus.issue_qk = 0;
        bus.cdb_valid = 0; bus.cdb_bus = 0;
        bus.fu_conf = 0; bus.fu_tag = 0;
    endtask

    task automatic set_issue(input logic [2:0] o, input logic [15:0] vj, input logic [15:0] vk,
                             input logic [2:0] qj, input logic [2:0] qk);
        bus.issue_valid = 1; bus.issue_op = o;
        bus.issue_vj = vj; bus.issue_vk = vk; bus.issue_qj = qj; bus.issue_qk = qk;
    endtask

    task automatic set_cdb(input logic [2:0] t, input logic [15:0] v);
        bus.cdb_valid = 1; bus.cdb_bus = {t, v};
    endtask

    task automatic confirm(input logic [2:0] t);
        bus.fu_conf = 1; bus.fu_tag = t;
    endtask

    task automatic check_outputs(input string where);
        logic [N-1:0] exp_busy;
        for (int i = 0; i < N; i++) exp_busy[i] = m_busy[i];
        check({where, ".Dado1"},    32'(bus.Dado1),    32'(m_d1));
        check({where, ".Dado2"},    32'(bus.Dado2),    32'(m_d2));
        check({where, ".op"},       32'(bus.op),       32'(m_op));
        check({where, ".ID_out"},   32'(bus.ID_out),   32'(m_id));
        check({where, ".busy_vec"}, 32'(bus.busy_vec), 32'(exp_busy));
    endtask

    // Check combinational outputs before the edge, advance one edge, then
    // check registered outputs 1 time unit later.
    task automatic tick(input string where);
        int fi;
        fi = model_first_free();
        check({where, ".issue_ready"}, 32'(bus.issue_ready), (fi >= 0) ? 32'd1 : 32'd0);
        check({where, ".issue_tag"},   32'(bus.issue_tag),   (fi >= 0) ? 32'(fi + BASE) : 32'd0);
        @(posedge CLK);
        model_step();
        #1;
        check_outputs(where);
    endtask

    // Let the model's "functional unit" confirm whatever executes until empty.
    task automatic drain(input string where);
        bit done;
        done = 0;
        idle_inputs();
        for (int c = 0; c < 60 && !done; c++) begin
            if (m_id != 0) confirm(m_id);
            else bus.fu_conf = 0;
            tick(where);
            if (model_all_free() && m_id == 0) done = 1;
        end
        idle_inputs();
        check({where, ".drain_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_reset();
        CLR = 0;
        #12;
        check_outputs("reset");
        CLR = 1;
        @(posedge CLK); #1;

        // 1: ready add dispatches on the next edge, freed by its confirmation.
        set_issue(3'b001, 16'd5, 16'd3, 3'd0, 3'd0);
        tick("t1_issue");
        idle_inputs();
        tick("t1_disp");
        check("t1_dado1_const", 32'(bus.Dado1), 32'd5);
        check("t1_dado2_const", 32'(bus.Dado2), 32'd3);
        check("t1_op_const",    32'(bus.op),    32'd1);
        check("t1_id_const",    32'(bus.ID_out), 32'd1);
        confirm(3'd1);
        tick("t1_conf");
        idle_inputs();
        check("t1_op_idle", 32'(bus.op), 32'd0);
        check("t1_busy_clear", 32'(bus.busy_vec), 32'd0);

        // 2: operand arrives on the CDB three cycles after issue.
        set_issue(3'b010, 16'd0, 16'd10, 3'd6, 3'd0);
        tick("t2_issue");
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            tick("t2_wait");
            check("t2_no_dispatch", 32'(bus.ID_out), 32'd0);
        end
        set_cdb(3'd6, 16'd20);
        tick("t2_cdb");
        idle_inputs();
        check("t2_not_same_edge", 32'(bus.ID_out), 32'd0);
        tick("t2_disp");
        check("t2_dado1_const", 32'(bus.Dado1), 32'd20);
        check("t2_dado2_const", 32'(bus.Dado2), 32'd10);
        check("t2_op_const",    32'(bus.op),    32'd2);
        drain("t2_drain");

        // 3: issue/CDB bypass on the Qk operand.
        set_issue(3'b011, 16'h0011, 16'd0, 3'd0, 3'd5);
        set_cdb(3'd5, 16'd7);
        tick("t3_issue");
        idle_inputs();
        tick("t3_disp");
        check("t3_id_const",    32'(bus.ID_out), 32'd1);
        check("t3_dado2_const", 32'(bus.Dado2),  32'd7);
        drain("t3_drain");

        // 4: fill the station, fourth issue held until an entry frees.
        set_issue(3'b001, 16'd1, 16'd1, 3'd0, 3'd0); tick("t4_i1");
        set_issue(3'b010, 16'd2, 16'd2, 3'd0, 3'd0); tick("t4_i2");
        set_issue(3'b001, 16'd3, 16'd3, 3'd0, 3'd0); tick("t4_i3");
        set_issue(3'b100, 16'd4, 16'd4, 3'd0, 3'd0);
        check("t4_full", 32'(bus.issue_ready), 32'd0);
        tick("t4_hold1");
        tick("t4_hold2");
        check("t4_id1_const", 32'(bus.ID_out), 32'd1);
        confirm(3'd1);
        tick("t4_conf1");
        bus.fu_conf = 0;
        check("t4_ready_after_free", 32'(bus.issue_ready), 32'd1);
        tick("t4_accept");
        bus.issue_valid = 0;
        check("t4_id2_const", 32'(bus.ID_out), 32'd2);
        check("t4_busy_full", 32'(bus.busy_vec), 32'b111);
        drain("t4_drain");

        // 5: ignored confirmations, then asynchronous reset mid-execution.
        set_issue(3'b001, 16'd9, 16'd8, 3'd0, 3'd0); tick("t5_i1");
        set_issue(3'b010, 16'd7, 16'd6, 3'd0, 3'd0); tick("t5_i2");
        idle_inputs();
        confirm(3'd1); tick("t5_conf1");
        idle_inputs(); tick("t5_disp2");
        check("t5_id2_const", 32'(bus.ID_out), 32'd2);
        confirm(3'd0); tick("t5_conf_tag0");
        confirm(3'd3); tick("t5_conf_tag3");
        idle_inputs();
        check("t5_id_held",  32'(bus.ID_out), 32'd2);
        check("t5_op_held",  32'(bus.op),     32'd2);
        check("t5_d1_held",  32'(bus.Dado1),  32'd7);
        #2;
        CLR = 0;
        #1;
        model_reset();
        check_outputs("t5_async_reset");
        #1;
        CLR = 1;
        confirm(3'd2);
        tick("t5_late_conf");
        idle_inputs();
        check("t5_late_conf_id", 32'(bus.ID_out), 32'd0);

        // 6: one broadcast satisfies both operands of two waiting entries.
        set_issue(3'b001, 16'd0, 16'd0, 3'd6, 3'd6); tick("t6_i1");
        set_issue(3'b010, 16'd0, 16'd0, 3'd6, 3'd6); tick("t6_i2");
        idle_inputs();
        tick("t6_wait");
        check("t6_none_ready", 32'(bus.ID_out), 32'd0);
        set_cdb(3'd6, 16'h1234); tick("t6_cdb");
        idle_inputs();
        tick("t6_disp1");
        check("t6_first_id", 32'(bus.ID_out), 32'd1);
        check("t6_first_d1", 32'(bus.Dado1),  32'h1234);
        check("t6_first_d2", 32'(bus.Dado2),  32'h1234);
        confirm(3'd1); tick("t6_conf1");
        idle_inputs();
        check("t6_idle_gap", 32'(bus.ID_out), 32'd0);
        tick("t6_disp2");
        check("t6_second_id", 32'(bus.ID_out), 32'd2);
        drain("t6_drain");

        // 7: random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            idle_inputs();
            if ($urandom_range(0, 1) == 1) begin
                set_issue(3'($urandom_range(1, 4)), 16'($urandom), 16'($urandom),
                          ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                          ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
            end
            if ($urandom_range(0, 1) == 1)
                set_cdb(3'($urandom_range(0, 7)), 16'($urandom));
            if (m_id != 0 && $urandom_range(0, 2) == 0) confirm(m_id);
            else if ($urandom_range(0, 3) == 0) confirm(3'($urandom_range(0, 7)));
            tick("rand");
        end
        // Release any operands still waiting, then empty the station.
        for (int t = 1; t < 8; t++) begin
            idle_inputs();
            set_cdb(3'(t), 16'($urandom));
            if (m_id != 0) confirm(m_id);
            tick("rand_flush");
        end
        drain("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
